// File: rtl/seq_pkg.sv
// seq_pkg: shared step count, FSM state encoding and counter sizing for the step sequencer
package seq_pkg;
  localparam int NUM_STEPS = 9;
  typedef enum logic {ST_STOPPED = 1'b0, ST_RUNNING = 1'b1} seq_state_e;
  function automatic int cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/seq_tick_divider.sv
// seq_tick_divider: loadable-period tick counter producing a terminal-count pulse
module seq_tick_divider #(
  parameter int W = 4,
  parameter logic [W-1:0] RST_PERIOD = W'(2)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] period,
  output logic         tc
);
  logic [W-1:0] cnt_q, cnt_d, per_q, per_d;
  assign tc = en && (cnt_q == per_q - 1'b1);
  // count up while enabled, restart on clear or terminal count; latch period on load
  always_comb begin
    cnt_d = (clr || tc) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    per_d = load ? period : per_q;
  end
  // counter and period registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      per_q <= RST_PERIOD;
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
    end
endmodule

// File: rtl/step_sequencer_core.sv
// step_sequencer_core: tempo-driven 9-step sequencer with note gate; SEQ_SWING_EN enables swing timing
module step_sequencer_core
  import seq_pkg::*;
#(
  parameter int TICKS_PER_STEP = 12_500_000,
  parameter int GATE_TICKS     = 6_250_000,
  parameter int SWING_TICKS    = 0
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iRUN,
  input  logic                 iSTEP_CLR,
  input  logic                 iPAT_WE,
  input  logic [NUM_STEPS-1:0] iPAT_DATA,
  output logic [NUM_STEPS-1:0] oSTEP_REG,
  output logic                 oSTEP_STROBE,
  output logic                 oNOTE_PLAYING,
  output logic                 oRUNNING
);
`ifdef SEQ_SWING_EN
  localparam int MAXP = TICKS_PER_STEP + SWING_TICKS;
  localparam int P0   = TICKS_PER_STEP + SWING_TICKS;
  localparam logic [NUM_STEPS-1:0] EVEN = 9'h055;
`else
  localparam int MAXP = TICKS_PER_STEP;
  localparam int P0   = TICKS_PER_STEP;
`endif
  localparam int MAXV = (MAXP > GATE_TICKS) ? MAXP : GATE_TICKS;
  localparam int W    = cnt_width(MAXV);
  if (TICKS_PER_STEP < 2 || GATE_TICKS < 1 || SWING_TICKS >= TICKS_PER_STEP - 1) begin : g_bad_params
    $error("step_sequencer_core: illegal timing parameters");
  end
  seq_state_e state_q, state_d;
  logic [NUM_STEPS-1:0] step_q, step_d, pat_q, pat_d;
  logic [W-1:0] gate_q, gate_d, period;
  logic strobe_q, strobe_d, note_q, note_d, active, enter, tc;
  assign active        = (state_q == ST_RUNNING) && iRUN;
  assign oSTEP_REG     = step_q;
  assign oSTEP_STROBE  = strobe_q;
  assign oNOTE_PLAYING = note_q;
  assign oRUNNING      = (state_q == ST_RUNNING);
  seq_tick_divider #(.W(W), .RST_PERIOD(W'(P0))) u_div (
    .clk   (iCLK),
    .rst   (iRST),
    .clr   (iSTEP_CLR || (state_q == ST_STOPPED && iRUN)),
    .en    (active),
    .load  (iSTEP_CLR || tc),
    .period(period),
    .tc    (tc)
  );
  // run/stop follows the iRUN level
  always_comb state_d = iRUN ? ST_RUNNING : ST_STOPPED;
  // state register
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) state_q <= ST_STOPPED;
    else state_q <= state_d;
  // period of the step being entered; step 8 and the unswung build use the base tempo
  always_comb begin
`ifdef SEQ_SWING_EN
    period = step_d[NUM_STEPS-1] ? W'(TICKS_PER_STEP) :
             |(step_d & EVEN) ? W'(TICKS_PER_STEP + SWING_TICKS) : W'(TICKS_PER_STEP - SWING_TICKS);
`else
    period = W'(TICKS_PER_STEP);
`endif
  end
  // step ring, strobe and gate; clear beats advance, stopping kills the gate
  always_comb begin
    step_d   = iSTEP_CLR ? NUM_STEPS'(1) : tc ? {step_q[NUM_STEPS-2:0], step_q[NUM_STEPS-1]} : step_q;
    enter    = active && (iSTEP_CLR || tc);
    strobe_d = enter;
    pat_d    = iPAT_WE ? iPAT_DATA : pat_q;
    gate_d   = enter ? (|(pat_q & step_d) ? W'(GATE_TICKS) : '0) :
               (active && |gate_q) ? gate_q - 1'b1 : '0;
    note_d   = |gate_d;
  end
  // datapath registers
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      step_q   <= NUM_STEPS'(1);
      pat_q    <= '0;
      gate_q   <= '0;
      strobe_q <= 1'b0;
      note_q   <= 1'b0;
    end else begin
      step_q   <= step_d;
      pat_q    <= pat_d;
      gate_q   <= gate_d;
      strobe_q <= strobe_d;
      note_q   <= note_d;
    end
endmodule

// File: tb/tb_step_sequencer_core.sv
// tb_step_sequencer_core: directed self-checking bench for step_sequencer_core (T=4, G=2, S=1)
module tb_step_sequencer_core;
  logic iCLK = 1'b0, iRST = 1'b1, iRUN = 1'b0, iSTEP_CLR = 1'b0, iPAT_WE = 1'b0;
  logic [8:0] iPAT_DATA = '0;
  logic [8:0] oSTEP_REG;
  logic oSTEP_STROBE, oNOTE_PLAYING, oRUNNING;
  int n_cmp = 0, n_bad = 0;
  int cur = 0;
  logic lastn = 1'b0;
  logic [8:0] pat_m = '0;
  always #5 iCLK = ~iCLK;
  step_sequencer_core #(.TICKS_PER_STEP(4), .GATE_TICKS(2), .SWING_TICKS(1)) dut (
    .iCLK(iCLK), .iRST(iRST), .iRUN(iRUN), .iSTEP_CLR(iSTEP_CLR), .iPAT_WE(iPAT_WE),
    .iPAT_DATA(iPAT_DATA), .oSTEP_REG(oSTEP_REG), .oSTEP_STROBE(oSTEP_STROBE),
    .oNOTE_PLAYING(oNOTE_PLAYING), .oRUNNING(oRUNNING)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int per(input int i);
`ifdef SEQ_SWING_EN
    return (i == 8) ? 4 : (i % 2 == 0) ? 5 : 3;
`else
    return 4;
`endif
  endfunction
  task automatic cyc();
    @(negedge iCLK);
    iPAT_WE = 1'b0;
    iSTEP_CLR = 1'b0;
  endtask
  task automatic wr_pat(input logic [8:0] p);
    iPAT_WE = 1'b1;
    iPAT_DATA = p;
    pat_m = p;
  endtask
  task automatic wait_strobe(output int n, output int nh);
    n = 0;
    nh = 0;
    do begin
      cyc();
      n++;
      if (!oSTEP_STROBE && oNOTE_PLAYING) nh++;
    end while (!oSTEP_STROBE && n < 20);
    if (!oSTEP_STROBE) chk("strobe_timeout", 0, 1);
  endtask
  task automatic run_steps(input string tag, input int k);
    int n, nh;
    for (int s = 0; s < k; s++) begin
      wait_strobe(n, nh);
      chk({tag, "_dur"}, n, per(cur));
      chk({tag, "_tail"}, nh, lastn ? 1 : 0);
      cur = (cur + 1) % 9;
      chk({tag, "_step"}, oSTEP_REG, 9'(1) << cur);
      chk({tag, "_note"}, oNOTE_PLAYING, pat_m[cur]);
      lastn = pat_m[cur];
    end
  endtask
  task automatic start_run(input string tag);
    iRUN = 1'b1;
    cyc();
    chk({tag, "_running"}, oRUNNING, 1);
    chk({tag, "_nostrobe"}, oSTEP_STROBE, 0);
    chk({tag, "_noretrig"}, oNOTE_PLAYING, 0);
    lastn = 1'b0;
  endtask
  initial begin
    int cnt;
    repeat (2) @(negedge iCLK);
    chk("rst_step", oSTEP_REG, 9'h001);
    chk("rst_strobe", oSTEP_STROBE, 0);
    chk("rst_note", oNOTE_PLAYING, 0);
    chk("rst_running", oRUNNING, 0);
    iRST = 1'b0;
    cyc();
    wr_pat(9'h1FF);
    start_run("t1");
    chk("t1_step0", oSTEP_REG, 9'h001);
    run_steps("t1", 9);
    wr_pat(9'h005);
    run_steps("t2", 9);
    wr_pat(9'h00D);
    run_steps("t3", 3);
    chk("t3_gate_before_stop", oNOTE_PLAYING, 1);
    iRUN = 1'b0;
    cyc();
    chk("t3_stop_running", oRUNNING, 0);
    chk("t3_stop_note", oNOTE_PLAYING, 0);
    chk("t3_stop_step", oSTEP_REG, 9'h008);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (oSTEP_STROBE) cnt++;
    end
    chk("t3_no_strobes", cnt, 0);
    chk("t3_held_step", oSTEP_REG, 9'h008);
    start_run("t3r");
    run_steps("t3r", 1);
    chk("t3r_step4", oSTEP_REG, 9'h010);
    run_steps("t4", 1);
    cnt = 0;
    for (int i = 0; i < per(cur) - 1; i++) begin
      cyc();
      if (oSTEP_STROBE) cnt++;
    end
    chk("t4_pre_tc", cnt, 0);
    iSTEP_CLR = 1'b1;
    cyc();
    chk("t4_clr_strobe", oSTEP_STROBE, 1);
    chk("t4_clr_step", oSTEP_REG, 9'h001);
    chk("t4_clr_note", oNOTE_PLAYING, pat_m[0]);
    cur = 0;
    lastn = pat_m[0];
    wr_pat(9'h000);
    run_steps("t4n", 4);
    chk("t5_in_step4", oSTEP_REG, 9'h010);
    wr_pat(9'h1FF);
    run_steps("t5", 1);
    chk("t5_note_step5", oNOTE_PLAYING, 1);
    run_steps("t6", 9);
    cyc();
    chk("t7_midgate", oNOTE_PLAYING, 1);
    iRST = 1'b1;
    iRUN = 1'b0;
    #1;
    chk("t7_rst_step", oSTEP_REG, 9'h001);
    chk("t7_rst_note", oNOTE_PLAYING, 0);
    chk("t7_rst_running", oRUNNING, 0);
    chk("t7_rst_strobe", oSTEP_STROBE, 0);
    cyc();
    iRST = 1'b0;
    cur = 0;
    pat_m = '0;
    start_run("t7r");
    run_steps("t7r", 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
